// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath and its upstream sequencer.
// Holds operand width, default length width and sequencer state codes.
package mac_pkg;

    localparam int DATA_W = 13;
    localparam int LEN_W  = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t CLEAR = 3'd1;
    localparam state_t RUN   = 3'd2;
    localparam state_t DRAIN = 3'd3;
    localparam state_t LOAD  = 3'd4;
    localparam state_t DONE  = 3'd5;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer feeding operand pairs to the MAC one per cycle.
// Clears the accumulator per vector, then pulses load and done.
module mac_seq_ctrl #(
    parameter int LEN_W  = mac_pkg::LEN_W,
    parameter int DATA_W = mac_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_clr_n,
    output logic              mac_ld,
    output logic              busy,
    output logic              done
);

    import mac_pkg::*;

    state_t             state;
    state_t             next_state;
    logic [LEN_W-1:0]   cnt;
    logic               hs;
    logic               last;

    logic [DATA_W-1:0]  a_d;
    logic [DATA_W-1:0]  b_d;
    logic               clr_n_d;
    logic               ld_d;
    logic               busy_d;
    logic               done_d;

    // Ready depends on state alone, so in_valid never reaches in_ready.
    assign in_ready = (state == RUN);
    assign hs       = in_valid & in_ready;
    assign last     = (cnt == LEN_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the pair that empties cnt ends RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = (cnt != '0) ? RUN : DRAIN;
            RUN:     if (hs && last) next_state = DRAIN;
            DRAIN:   next_state = LOAD;
            LOAD:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: values the output registers take at the next edge.
    always_comb begin
        a_d     = '0;
        b_d     = '0;
        clr_n_d = 1'b1;
        ld_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = (next_state != IDLE);
        if (hs) begin
            a_d = in_a;
            b_d = in_b;
        end
        case (next_state)
            CLEAR:   clr_n_d = 1'b0;
            LOAD:    ld_d    = 1'b1;
            DONE:    done_d  = 1'b1;
            default: ;
        endcase
    end

    // Remaining element count; len is only taken when leaving IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == IDLE && start) begin
            cnt <= len;
        end else if (hs) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    // Registered MAC-side outputs; bubbles present zero operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_a     <= '0;
            mac_b     <= '0;
            mac_clr_n <= 1'b1;
            mac_ld    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mac_a     <= a_d;
            mac_b     <= b_d;
            mac_clr_n <= clr_n_d;
            mac_ld    <= ld_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural MAC and a timeline model.
// Directed vectors pin the model; random vectors exercise the rest.
module tb_mac_seq_ctrl;

    localparam int LW = 8;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_ready;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_clr_n;
    logic          mac_ld;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.LEN_W(LW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b),
        .mac_clr_n(mac_clr_n), .mac_ld(mac_ld),
        .busy(busy), .done(done)
    );

    // Behavioural MAC: accumulator reset by mac_clr_n, output on mac_ld.
    logic [31:0] acc;
    logic [31:0] mac_out;
    always @(posedge clk or negedge mac_clr_n) begin
        if (!mac_clr_n) acc <= 32'd0;
        else            acc <= acc + 32'(mac_a) * 32'(mac_b);
    end
    always @(posedge clk) begin
        if (mac_ld) mac_out <= acc;
    end

    int checks = 0;
    int failures = 0;

    logic          chk_en = 1'b0;
    logic          e_ready, e_clr_n, e_ld, e_busy, e_done, e_out_en;
    logic [DW-1:0] e_a, e_b;
    logic [31:0]   e_out;

    logic [DW-1:0] fa[$];
    logic [DW-1:0] fb[$];
    bit            fv[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  32'(in_ready),  32'(e_ready));
            chk("mac_a",     32'(mac_a),     32'(e_a));
            chk("mac_b",     32'(mac_b),     32'(e_b));
            chk("mac_clr_n", 32'(mac_clr_n), 32'(e_clr_n));
            chk("mac_ld",    32'(mac_ld),    32'(e_ld));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("done",      32'(done),      32'(e_done));
            if (e_out_en) chk("mac_out", mac_out, e_out);
        end
    end

    task automatic set_idle_exp();
        e_ready  = 1'b0;
        e_a      = '0;
        e_b      = '0;
        e_clr_n  = 1'b1;
        e_ld     = 1'b0;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_out_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs(input int k, inout int ld_c, inout int dn_c,
                       inout logic [31:0] r);
        if (mac_ld) ld_c = k;
        if (done) begin
            dn_c = k;
            r    = mac_out;
        end
    endtask

    // Walks one vector: start in cycle 0, CLEAR in cycle 1, then RUN
    // until n pairs are taken, DRAIN, LOAD and DONE, ending in IDLE.
    task automatic run_vec(input int n, input bit poke,
                           output logic [31:0] res,
                           output int ld_cyc, output int done_cyc);
        int k;
        int got;
        int guard;
        bit v;
        logic [DW-1:0] pa, pb;
        logic [31:0] sum;
        sum = 0; pa = '0; pb = '0; got = 0; guard = 0;
        ld_cyc = -1; done_cyc = -1; res = 'x;

        set_idle_exp();
        start = 1'b1; len = LW'(n);
        in_valid = 1'($urandom_range(1));
        in_a = DW'($urandom); in_b = DW'($urandom);
        tick(); k = 1;
        start = 1'b0; len = LW'($urandom);

        obs(k, ld_cyc, done_cyc, res);
        e_clr_n = 1'b0; e_busy = 1'b1;
        in_valid = 1'($urandom_range(1));
        tick(); k++;
        e_clr_n = 1'b1;

        while (got < n && guard < 600) begin
            obs(k, ld_cyc, done_cyc, res);
            e_ready = 1'b1; e_a = pa; e_b = pb;
            v = (fv.size() > 0) ? fv.pop_front()
                                : ($urandom_range(99) < 75);
            in_valid = v;
            in_a = (v && fa.size() > 0) ? fa.pop_front() : DW'($urandom);
            in_b = (v && fb.size() > 0) ? fb.pop_front() : DW'($urandom);
            start = poke && guard == 1;
            len = LW'($urandom);
            if (v) begin
                pa = in_a; pb = in_b;
                sum += 32'(pa) * 32'(pb);
                got++;
            end else begin
                pa = '0; pb = '0;
            end
            tick(); k++; guard++;
            start = 1'b0;
        end
        if (guard >= 600) begin
            checks++; failures++;
            $display("FAIL run_bound: got %0d pairs expected %0d", got, n);
        end

        obs(k, ld_cyc, done_cyc, res);
        e_ready = 1'b0; e_a = pa; e_b = pb;
        in_valid = 1'($urandom_range(1));
        tick(); k++;

        obs(k, ld_cyc, done_cyc, res);
        e_a = '0; e_b = '0; e_ld = 1'b1;
        tick(); k++;

        obs(k, ld_cyc, done_cyc, res);
        e_ld = 1'b0; e_done = 1'b1;
        e_out_en = 1'b1; e_out = sum;
        tick();

        in_valid = 1'b0;
        set_idle_exp();
    endtask

    logic [31:0] r;
    int lc, dc;

    initial begin
        set_idle_exp();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        fa = '{1, 3, 5, 7}; fb = '{2, 4, 6, 8}; fv = '{1, 1, 1, 1};
        run_vec(4, 1'b0, r, lc, dc);
        chk("t1_out", r, 100); chk("t1_ld", lc, 7); chk("t1_done", dc, 8);
        tick();

        fa = '{1, 3, 5, 7}; fb = '{2, 4, 6, 8}; fv = '{1, 0, 1, 0, 1, 1};
        run_vec(4, 1'b0, r, lc, dc);
        chk("t2_out", r, 100); chk("t2_done", dc, 10);
        tick();

        run_vec(0, 1'b0, r, lc, dc);
        chk("t3_out", r, 0); chk("t3_ld", lc, 3); chk("t3_done", dc, 4);
        tick();

        fa = '{2, 4}; fb = '{3, 5}; fv = '{1, 1};
        run_vec(2, 1'b0, r, lc, dc);
        chk("t4a_out", r, 26); chk("t4a_done", dc, 6);
        fa = '{6}; fb = '{7}; fv = '{1};
        run_vec(1, 1'b0, r, lc, dc);
        chk("t4b_out", r, 42); chk("t4b_done", dc, 5);
        tick();

        fa = '{1, 3, 5, 7}; fb = '{2, 4, 6, 8}; fv = '{1, 1, 1, 1};
        run_vec(4, 1'b1, r, lc, dc);
        chk("t5_out", r, 100); chk("t5_done", dc, 8);
        tick();

        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        e_clr_n = 1'b0; e_busy = 1'b1;
        tick();
        e_clr_n = 1'b1; e_ready = 1'b1;
        in_valid = 1'b1; in_a = 13'd3; in_b = 13'd3;
        tick();
        e_a = 13'd3; e_b = 13'd3;
        in_a = 13'd4; in_b = 13'd4;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        set_idle_exp();
        tick();
        rst = 1'b1;
        tick();
        fa = '{9}; fb = '{9}; fv = '{1};
        run_vec(1, 1'b0, r, lc, dc);
        chk("t6_out", r, 81); chk("t6_done", dc, 5);
        tick();

        repeat (25) begin
            run_vec($urandom_range(12), 1'($urandom_range(1)), r, lc, dc);
            repeat ($urandom_range(2)) tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Upstream sequencer for the MAC unit. It accepts a dot-product length and a valid/ready stream of 13-bit operand pairs, and issues each pair to the MAC one per cycle. It clears the MAC accumulator before every vector and pulses the MAC output-register load once the final product has been accumulated. It also signals completion, so back-to-back dot products are possible without a system reset.

## Interface
- LEN_W, 8: width of vector-length field and element counter
- DATA_W, 13: operand width; must match the MAC operand ports
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a vector; sampled only in IDLE
- len  in  LEN_W  number of operand pairs; latched on accepted start
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts the pair this cycle
- in_a, in_b  in  DATA_W  operand pair
- mac_a, mac_b  out  DATA_W  registered operands to MAC a/b inputs
- mac_clr_n  out  1  registered, active-low; drives the MAC accumulator reset
- mac_ld  out  1  registered; drives the MAC ld input
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: MAC output holds the final sum

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, LOAD, DONE.
- IDLE: in_ready=0, mac_a=mac_b=0, mac_clr_n=1, mac_ld=0.
  - On start=1: latch len into cnt, go to CLEAR.
- CLEAR: mac_clr_n=0 for exactly one cycle, operands 0.
  - Next state is RUN if cnt≠0, else DRAIN.
- RUN: in_ready=1.
  - On in_valid&in_ready: mac_a/mac_b ← in_a/in_b at the edge, and cnt decrements.
  - If no handshake occurs, mac_a/mac_b ← 0 at the edge. Bubbles therefore add zero and the accumulator holds.
  - Acceptance of the pair that takes cnt from 1 to 0 moves to DRAIN.
- DRAIN: last pair is presented on mac_a/mac_b and accumulated at the end of this cycle. in_ready=0.
- LOAD: operands 0, mac_ld=1 for one cycle; the MAC output register captures the final accumulator.
- DONE: done=1 for one cycle, operands 0, then go to IDLE.
- start is ignored while busy=1. len is not re-sampled mid-vector.
- len=0: sequence is CLEAR→DRAIN→LOAD→DONE, and the MAC output becomes 0.
- No arithmetic is performed on operands. cnt is unsigned LEN_W bits and never wraps; a decrement from 0 is unreachable.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - mac_a=mac_b=0, mac_clr_n=1.
  - mac_ld=0, in_ready=0, busy=0, done=0.
- Reset mid-operation immediately returns to IDLE with the values above. The MAC output register contents are undefined until the next full vector.
- All outputs are registered, except in_ready, which is decoded from state only (no combinational path from in_valid).
- With start accepted at edge 0 and in_valid held high:
  - CLEAR in cycle 1.
  - RUN in cycles 2..N+1, with N pairs accepted.
  - DRAIN in cycle N+2.
  - LOAD in cycle N+3.
  - DONE in cycle N+4; MAC output is valid from this cycle.
- Each bubble cycle in RUN adds one cycle of latency.
- The next start may be asserted during DONE's following IDLE cycle. Minimum vector-to-vector spacing is N+5 cycles.

## Structure
- Shared package mac_pkg holds:
  - DATA_W=13 and the default LEN_W.
  - The sequencer state encoding as named localparams: IDLE=0, CLEAR=1, RUN=2, DRAIN=3, LOAD=4, DONE=5.
- Single module with no sub-module. Operand, counter and control registers are all inline.
- The top level instantiates mac_seq_ctrl next to the MAC unit:
  - mac_a, mac_b, mac_ld connect directly to the MAC.
  - mac_clr_n connects to the MAC reset.

## Test plan
- len=4, pairs (1,2),(3,4),(5,6),(7,8), in_valid held high → mac_ld in cycle 7, done in cycle 8, MAC output = 100.
- Same vector with in_valid low in two cycles inside RUN → mac_a/mac_b are 0 in the bubble cycles, done in cycle 10, output = 100.
- len=0 → mac_clr_n low in cycle 1, no in_ready, done in cycle 4, output = 0.
- Back-to-back vectors: len=2 (2,3),(4,5) then len=1 (6,7) → first output 26, second output 42 (accumulator cleared between vectors).
- start pulsed during RUN → ignored, cnt unchanged, result unchanged.
- rst low for one cycle during RUN → all outputs at reset values immediately; a subsequent len=1 (9,9) gives 81.
